// File: rtl/score_counter_if.sv
// Signal bundle between the game-state pulse sources and the score engine.
// The slave side is the score_counter; the master side drives the pulses and reads the score.
interface score_counter_if #(
  parameter int unsigned DIGITS = 4
);
  logic                  i_game_tick;
  logic                  i_game_start_pulse;
  logic                  i_game_over_pulse;
  logic [4*DIGITS-1:0]   o_score_bcd;
  logic [4*DIGITS-1:0]   o_high_score_bcd;
  logic                  o_running;
  logic                  o_milestone_pulse;
  logic [2:0]            o_speed_level;

  modport master (
    output i_game_tick, i_game_start_pulse, i_game_over_pulse,
    input  o_score_bcd, o_high_score_bcd, o_running, o_milestone_pulse, o_speed_level
  );

  modport slave (
    input  i_game_tick, i_game_start_pulse, i_game_over_pulse,
    output o_score_bcd, o_high_score_bcd, o_running, o_milestone_pulse, o_speed_level
  );
endinterface

// File: rtl/score_counter.sv
// BCD game-score engine with tick prescaler, 100-point milestones and speed level.
// Optional best-score register enabled by macro SCORE_HIGH_SCORE_EN.
module score_counter #(
  parameter int unsigned DIGITS          = 4,
  parameter int unsigned TICKS_PER_POINT = 6,
  parameter int unsigned SPEED_MAX       = 7
) (
  input  logic            clk,
  input  logic            rst,
  score_counter_if.slave  bus
);

  localparam int unsigned SW    = 4 * DIGITS;
  localparam bit          MS_EN = (DIGITS >= 3);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_OVER} state_e;

  state_e          state_q, state_d;
  logic [SW-1:0]   score_q, score_d;
  logic [7:0]      presc_q, presc_d;
  logic            ms_q, ms_d;
  logic [2:0]      speed_q, speed_d;
  logic            running_q, running_d;

  logic [SW-1:0]   inc_score;
  logic            sat;
  logic            low_roll;

  // Ripple-carry BCD increment; a carry out of the top digit means all-9s.
  always_comb begin : bcd_inc
    logic       carry;
    logic [3:0] dig;
    inc_score = score_q;
    carry     = 1'b1;
    low_roll  = 1'b1;
    dig       = 4'd0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      dig = score_q[4*i +: 4];
      if (i < 2 && dig != 4'd9) low_roll = 1'b0;
      if (carry) begin
        if (dig == 4'd9) begin
          inc_score[4*i +: 4] = 4'd0;
        end else begin
          inc_score[4*i +: 4] = 4'(dig + 4'd1);
          carry               = 1'b0;
        end
      end
    end
    sat = carry;
  end

`ifdef SCORE_HIGH_SCORE_EN
  logic [SW-1:0] hs_q, hs_d;
`endif

  always_comb begin
    state_d = state_q;
    score_d = score_q;
    presc_d = presc_q;
    ms_d    = 1'b0;
    speed_d = speed_q;
`ifdef SCORE_HIGH_SCORE_EN
    hs_d    = hs_q;
`endif
    unique case (state_q)
      S_IDLE, S_OVER: begin
        if (bus.i_game_start_pulse) begin
          state_d = S_RUN;
          score_d = '0;
          presc_d = 8'd0;
          speed_d = 3'd0;
        end
      end
      S_RUN: begin
        // Crash takes priority over both a coincident start and tick.
        if (bus.i_game_over_pulse) begin
          state_d = S_OVER;
`ifdef SCORE_HIGH_SCORE_EN
          if (score_q > hs_q) hs_d = score_q;
`endif
        end else if (bus.i_game_tick) begin
          if (presc_q == 8'(TICKS_PER_POINT - 1)) begin
            presc_d = 8'd0;
            if (!sat) begin
              score_d = inc_score;
              if (MS_EN && low_roll) begin
                ms_d = 1'b1;
                if (speed_q < 3'(SPEED_MAX)) speed_d = 3'(speed_q + 3'd1);
              end
            end
          end else begin
            presc_d = 8'(presc_q + 8'd1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    running_d = (state_d == S_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      score_q   <= '0;
      presc_q   <= 8'd0;
      ms_q      <= 1'b0;
      speed_q   <= 3'd0;
      running_q <= 1'b0;
`ifdef SCORE_HIGH_SCORE_EN
      hs_q      <= '0;
`endif
    end else begin
      state_q   <= state_d;
      score_q   <= score_d;
      presc_q   <= presc_d;
      ms_q      <= ms_d;
      speed_q   <= speed_d;
      running_q <= running_d;
`ifdef SCORE_HIGH_SCORE_EN
      hs_q      <= hs_d;
`endif
    end
  end

  assign bus.o_score_bcd       = score_q;
  assign bus.o_running         = running_q;
  assign bus.o_milestone_pulse = ms_q;
  assign bus.o_speed_level     = speed_q;
`ifdef SCORE_HIGH_SCORE_EN
  assign bus.o_high_score_bcd  = hs_q;
`else
  assign bus.o_high_score_bcd  = '0;
`endif

endmodule

// File: tb/tb_score_counter.sv
// Directed bench for score_counter: 4-digit instance for the main flow, 2-digit instance for saturation.
module tb_score_counter;

  logic clk;
  logic rst;

  score_counter_if #(.DIGITS(4)) bus4 ();
  score_counter_if #(.DIGITS(2)) bus2 ();

  score_counter #(.DIGITS(4), .TICKS_PER_POINT(6), .SPEED_MAX(7)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  score_counter #(.DIGITS(2), .TICKS_PER_POINT(6), .SPEED_MAX(7)) u_dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

`ifdef SCORE_HIGH_SCORE_EN
  localparam bit HS = 1'b1;
`else
  localparam bit HS = 1'b0;
`endif

  int total = 0;
  int bad   = 0;
  int ms4_cnt = 0;
  int ms2_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus4.o_milestone_pulse === 1'b1) ms4_cnt++;
    if (bus2.o_milestone_pulse === 1'b1) ms2_cnt++;
  end

  typedef struct {
    int          n;
    logic        tick;
    logic        start;
    logic        over;
    logic [15:0] score;
    logic        run;
    logic        ms;
    logic [2:0]  spd;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  // Apply the given inputs for n cycles; returns 1 time unit after the last edge.
  task automatic cyc(input bit sel2, input logic t, input logic s, input logic o, input int n);
    for (int k = 0; k < n; k++) begin
      if (sel2) begin
        bus2.i_game_tick = t; bus2.i_game_start_pulse = s; bus2.i_game_over_pulse = o;
      end else begin
        bus4.i_game_tick = t; bus4.i_game_start_pulse = s; bus4.i_game_over_pulse = o;
      end
      @(posedge clk);
      #1;
    end
    bus4.i_game_tick = 1'b0; bus4.i_game_start_pulse = 1'b0; bus4.i_game_over_pulse = 1'b0;
    bus2.i_game_tick = 1'b0; bus2.i_game_start_pulse = 1'b0; bus2.i_game_over_pulse = 1'b0;
  endtask

  task automatic hs_run(input int pts, input logic [15:0] exp_hs, input string nm);
    cyc(0, 0, 1, 0, 1);
    cyc(0, 1, 0, 0, pts * 6);
    cyc(0, 0, 0, 1, 1);
    chk({nm, " running"}, 32'(bus4.o_running), 32'(0));
    chk({nm, " hs"}, 32'(bus4.o_high_score_bcd), 32'(exp_hs));
  endtask

  initial begin
    vecs[0]  = '{1,  1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 3'd0};
    vecs[1]  = '{20, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 3'd0};
    vecs[2]  = '{1,  1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 3'd0};
    vecs[3]  = '{11, 1'b1, 1'b0, 1'b0, 16'h0001, 1'b1, 1'b0, 3'd0};
    vecs[4]  = '{1,  1'b1, 1'b0, 1'b0, 16'h0002, 1'b1, 1'b0, 3'd0};
    vecs[5]  = '{5,  1'b1, 1'b0, 1'b0, 16'h0002, 1'b1, 1'b0, 3'd0};
    vecs[6]  = '{1,  1'b1, 1'b0, 1'b0, 16'h0003, 1'b1, 1'b0, 3'd0};
    vecs[7]  = '{1,  1'b1, 1'b0, 1'b1, 16'h0003, 1'b0, 1'b0, 3'd0};
    vecs[8]  = '{12, 1'b1, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0, 3'd0};
    vecs[9]  = '{1,  1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 3'd0};
    vecs[10] = '{5,  1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 3'd0};
    vecs[11] = '{1,  1'b1, 1'b0, 1'b0, 16'h0001, 1'b1, 1'b0, 3'd0};
    vecs[12] = '{1,  1'b0, 1'b1, 1'b1, 16'h0001, 1'b0, 1'b0, 3'd0};
    vecs[13] = '{1,  1'b0, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b0, 3'd0};
    vecs[14] = '{1,  1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 3'd0};

    rst = 1'b1;
    bus4.i_game_tick = 1'b0; bus4.i_game_start_pulse = 1'b0; bus4.i_game_over_pulse = 1'b0;
    bus2.i_game_tick = 1'b0; bus2.i_game_start_pulse = 1'b0; bus2.i_game_over_pulse = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset hs", 32'(bus4.o_high_score_bcd), 32'(0));

    for (int i = 0; i < 15; i++) begin
      cyc(0, vecs[i].tick, vecs[i].start, vecs[i].over, vecs[i].n);
      chk($sformatf("vec%0d score", i), 32'(bus4.o_score_bcd), 32'(vecs[i].score));
      chk($sformatf("vec%0d running", i), 32'(bus4.o_running), 32'(vecs[i].run));
      chk($sformatf("vec%0d milestone", i), 32'(bus4.o_milestone_pulse), 32'(vecs[i].ms));
      chk($sformatf("vec%0d speed", i), 32'(bus4.o_speed_level), 32'(vecs[i].spd));
    end

    // Climb to 99, then cross the first 100-point boundary.
    cyc(0, 1, 0, 0, 99 * 6);
    chk("to99 score", 32'(bus4.o_score_bcd), 32'h0099);
    chk("to99 speed", 32'(bus4.o_speed_level), 32'(0));
    cyc(0, 1, 0, 0, 5);
    chk("pre100 score", 32'(bus4.o_score_bcd), 32'h0099);
    chk("pre100 ms", 32'(bus4.o_milestone_pulse), 32'(0));
    cyc(0, 1, 0, 0, 1);
    chk("at100 score", 32'(bus4.o_score_bcd), 32'h0100);
    chk("at100 ms", 32'(bus4.o_milestone_pulse), 32'(1));
    chk("at100 speed", 32'(bus4.o_speed_level), 32'(1));
    cyc(0, 0, 0, 0, 1);
    chk("post100 ms", 32'(bus4.o_milestone_pulse), 32'(0));
    chk("post100 ms cycles", 32'(ms4_cnt), 32'(1));

    // Eight and nine milestones: speed saturates at 7.
    cyc(0, 1, 0, 0, 700 * 6);
    cyc(0, 0, 0, 0, 1);
    chk("at800 score", 32'(bus4.o_score_bcd), 32'h0800);
    chk("at800 ms cycles", 32'(ms4_cnt), 32'(8));
    chk("at800 speed", 32'(bus4.o_speed_level), 32'(7));
    cyc(0, 1, 0, 0, 100 * 6);
    cyc(0, 0, 0, 0, 1);
    chk("at900 score", 32'(bus4.o_score_bcd), 32'h0900);
    chk("at900 ms cycles", 32'(ms4_cnt), 32'(9));
    chk("at900 speed", 32'(bus4.o_speed_level), 32'(7));

    // Reset mid-run.
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst score", 32'(bus4.o_score_bcd), 32'(0));
    chk("midrst running", 32'(bus4.o_running), 32'(0));
    chk("midrst speed", 32'(bus4.o_speed_level), 32'(0));
    chk("midrst hs", 32'(bus4.o_high_score_bcd), 32'(0));

    hs_run(42,  HS ? 16'h0042 : 16'h0000, "run42");
    chk("run42 score", 32'(bus4.o_score_bcd), 32'h0042);
    hs_run(17,  HS ? 16'h0042 : 16'h0000, "run17");
    chk("run17 score", 32'(bus4.o_score_bcd), 32'h0017);
    hs_run(105, HS ? 16'h0105 : 16'h0000, "run105");
    chk("run105 score", 32'(bus4.o_score_bcd), 32'h0105);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("hs after rst", 32'(bus4.o_high_score_bcd), 32'(0));

    // Two-digit instance: saturation at 99, never a milestone.
    cyc(1, 0, 1, 0, 1);
    cyc(1, 1, 0, 0, 99 * 6);
    chk("d2 to99 score", 32'(bus2.o_score_bcd), 32'h99);
    cyc(1, 1, 0, 0, 12);
    cyc(1, 0, 0, 0, 1);
    chk("d2 sat score", 32'(bus2.o_score_bcd), 32'h99);
    chk("d2 sat running", 32'(bus2.o_running), 32'(1));
    chk("d2 sat speed", 32'(bus2.o_speed_level), 32'(0));
    chk("d2 ms cycles", 32'(ms2_cnt), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/score_counter.md
Name: score_counter

Overview:
- Game-score engine that produces the BCD digit vector consumed by score_render, replacing its constant `num` tie-off.
- Sits between the game-state pulses (player_controller, graphics_top tick outputs) and score_render.
- Counts points while a run is active, freezes on crash, and emits milestone and speed-level information for obstacle pacing.

Parameters:
- DIGITS, 4, number of BCD digits in the score (each 4 bits).
- TICKS_PER_POINT, 6, number of i_game_tick pulses per score increment; legal range 1..255.
- SPEED_MAX, 7, saturation value of o_speed_level; legal range 1..7.

Ports:
- clk  in  1  system clock (VGA pixel clock domain).
- rst  in  1  synchronous reset, active-high.
- i_game_tick  in  1  one-cycle pulse, game tick (20 Hz stage-0 pulse).
- i_game_start_pulse  in  1  one-cycle pulse, new run begins.
- i_game_over_pulse  in  1  one-cycle pulse, crash / run ended.
- o_score_bcd  out  4*DIGITS  current score; digit 0 in bits [3:0].
- o_high_score_bcd  out  4*DIGITS  best score since reset (see Optional Feature).
- o_running  out  1  high while in RUN.
- o_milestone_pulse  out  1  one-cycle pulse on every 100-point boundary.
- o_speed_level  out  3  count of milestones this run, saturating at SPEED_MAX.

Behaviour:
- All outputs are registered.
- Reset values: state=IDLE, score=0, high score=0, prescaler=0, o_running=0, o_milestone_pulse=0, o_speed_level=0.
- FSM states: IDLE, RUN, OVER.
  - IDLE: on i_game_start_pulse -> RUN; clear score, prescaler, and speed level.
  - RUN: on i_game_over_pulse -> OVER; score freezes.
  - OVER: on i_game_start_pulse -> RUN; clear as in IDLE.
  - i_game_over_pulse is ignored in IDLE and OVER.
- Prescaler (8-bit):
  - Counts i_game_tick pulses only in RUN.
  - On a tick with prescaler==TICKS_PER_POINT-1: prescaler->0 and the score increments; otherwise prescaler+1.
- Score increment:
  - Ripple-carry BCD. A digit at 9 with carry-in becomes 0 and carries.
  - Each digit stays in 0..9 at all times.
  - Saturation: if all digits are 9, the score holds at all-9s, no carry out, no milestone.
- Latency: o_score_bcd reflects the increment on the cycle after the triggering tick is sampled.
- o_milestone_pulse:
  - High for exactly one cycle, coincident with the o_score_bcd update, when an increment rolls digits 1..0 from 99 to 00 (score N99 -> (N+1)00).
  - Never asserted when saturated.
  - Requires DIGITS>=3; for DIGITS<3 it is tied to 0.
- o_speed_level: increments alongside each milestone pulse and saturates at SPEED_MAX; cleared on start.
- Simultaneous events:
  - RUN with over+start in the same cycle: over wins, go to OVER; start is ignored.
  - Tick coincident with over: the tick is ignored and no increment occurs.
  - Tick coincident with start (IDLE/OVER): the tick is ignored; prescaler=0 after the start.
- rst asserted mid-run: all state returns to the reset values on the next clock edge, including the high score.
- o_running = (state==RUN).

Optional Feature:
- Macro: SCORE_HIGH_SCORE_EN.
- Defined: o_high_score_bcd is a register. On the RUN->OVER transition it loads the score if score > high score. Unsigned compare of the packed BCD vectors is valid because BCD ordering equals numeric ordering. The update is visible on the same cycle o_running falls.
- Undefined: no high-score register is synthesised and o_high_score_bcd is constant 0.

Test Plan:
- Reset, then 20 ticks in IDLE -> o_score_bcd=0, o_running=0, prescaler untouched.
- Start, then 12 ticks (TICKS_PER_POINT=6) -> score=0x0002 one cycle after the 12th tick; 5 more ticks -> still 0x0002; 1 more -> 0x0003.
- Preload path: run to score 0x0099, then 6 ticks -> score=0x0100, o_milestone_pulse high exactly 1 cycle, o_speed_level=1. Eight milestones -> o_speed_level stays 7.
- Saturation: DIGITS=2, drive to 0x99, then 12 more ticks -> score stays 0x99, no milestone pulse.
- Over+start in same cycle while RUN -> OVER, score frozen. Further ticks -> no change. Start next cycle -> score=0, prescaler=0, RUN.
- With SCORE_HIGH_SCORE_EN:
  - Runs ending at 0x0042 then 0x0017 -> high score 0x0042.
  - A third run ending at 0x0105 -> 0x0105.
  - rst -> 0x0000.
  - Without the macro -> always 0.
